// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_pkg;

   localparam int XLEN = 32;

   // Canonical NOP (addi x0, x0, 0) shown to decode when nothing is valid.
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // Default first fetch address after reset.
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Saturating increment for the performance counters.
   function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO of fetched instructions. Slot 0 is always the head,
// so the head is a plain register read with no pointer mux in front of it.
module fetch_buffer
   import riscv_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output fetch_entry_t head,
   output logic [1:0]   occupancy
);

   fetch_entry_t entry_q [2];
   logic [1:0]   occ_q;

   // Occupancy: flush wins over push/pop; reset is synchronous.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q <= 2'd0;
      end else if (flush) begin
         occ_q <= 2'd0;
      end else begin
         occ_q <= occ_q + 2'(push) - 2'(pop);
      end
   end

   // Entry storage: shift toward slot 0 on pop, write the first free slot on push.
   // NOTE: the data slots are deliberately not reset; occupancy alone decides
   // which slots are live, and the top masks the head when occupancy is zero.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (pop) begin
            entry_q[0] <= (push && occ_q == 2'd1) ? push_entry : entry_q[1];
            if (push && occ_q == 2'd2) begin
               entry_q[1] <= push_entry;
            end
         end else if (push) begin
            if (occ_q == 2'd0) begin
               entry_q[0] <= push_entry;
            end else begin
               entry_q[1] <= push_entry;
            end
         end
      end
   end

   assign head      = entry_q[0];
   assign occupancy = occ_q;

   // The issue rule upstream guarantees space; a push into a full buffer
   // or a pop from an empty one means that rule is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && !flush && occ_q == 2'd2));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && !flush && occ_q == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, hides the
// ROM's one-cycle read latency and hands {pc, instr} to decode over valid/ready.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault,
   output logic [31:0] fault_pc,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
);

   logic [31:0]  pc_q, pc_d;
   logic         inflight_q;
   logic [31:0]  inflight_pc_q;
   logic         fault_q;
   logic [31:0]  fault_pc_q;
   logic [31:0]  perf_fetched_q, perf_stall_q;

   logic         deq, redirect_taken, issue, push, pop;
   logic [2:0]   pending;
   logic [1:0]   occ;
   fetch_entry_t head;

   assign if_valid = (occ != 2'd0);

   // Handshake, issue decision and next PC.
   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      deq            = if_valid & id_ready;
      redirect_taken = redirect_valid & ~fault_q;
      pending        = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
      issue          = ~fault_q & ~redirect_valid & (pending < 3'(BUF_DEPTH));
      push           = inflight_q & ~redirect_valid;
      pop            = deq & ~redirect_valid;
      pc_d           = pc_q;
      if (redirect_taken) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d = pc_q + 32'd4;
      end
   end

   // PC and in-flight ROM read tracking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= issue;
         if (issue) begin
            inflight_pc_q <= pc_q;
         end
      end
   end

   // Sticky misaligned-redirect fault; only the first one is recorded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else if (redirect_taken && redirect_pc[1:0] != 2'b00) begin
         fault_q    <= 1'b1;
         fault_pc_q <= redirect_pc;
      end
   end

   // Saturating performance counters; a transfer squashed by a redirect is not counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (deq && !redirect_valid) begin
            perf_fetched_q <= sat_inc(perf_fetched_q);
         end
         if (if_valid && !id_ready) begin
            perf_stall_q <= sat_inc(perf_stall_q);
         end
      end
   end

   fetch_buffer u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_valid),
      .push_entry ({inflight_pc_q, imem_instr}),
      .head       (head),
      .occupancy  (occ)
   );

   assign imem_addr    = pc_q;
   assign if_pc        = if_valid ? head.pc : '0;
   assign if_instr     = if_valid ? head.instr : NOP_INSTR;
   assign fetch_fault  = fault_q;
   assign fault_pc     = fault_pc_q;
   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Owns the PC and drives the ROM address.
- Absorbs the ROM's one-cycle synchronous read latency and presents {pc, instr} pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects, flushes wrong-path fetches, and flags misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, entries in the fetch buffer; fixed at 2, not user-scaled.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  32  ROM address; driven directly from pc_q with no combinational input path.
- imem_instr  in  32  ROM data; equals ROM word for the imem_addr sampled at the previous edge.
- if_valid  out  1  buffer head holds a valid instruction.
- if_pc  out  32  PC of head entry.
- if_instr  out  32  instruction of head entry; 32'h0000_0013 (NOP) when if_valid=0.
- id_ready  in  1  decode accepts head this cycle.
- redirect_valid  in  1  taken branch/jump/exception redirect.
- redirect_pc  in  32  redirect target.
- fetch_fault  out  1  sticky misaligned-redirect fault.
- fault_pc  out  32  offending redirect_pc.
- perf_fetched  out  32  count of accepted transfers (if_valid & id_ready).
- perf_stall  out  32  count of cycles with if_valid & !id_ready.

Behaviour:
- Reset, synchronous, at an edge with rst_n=0:
  - pc_q=RESET_PC, inflight_q=0, buffer occupancy=0.
  - if_valid=0, if_pc=0, if_instr=NOP.
  - fetch_fault=0, fault_pc=0, perf counters=0.
  - A reset mid-operation discards in-flight and buffered entries at that edge.
- deq = if_valid & id_ready.
- Issue rule: issue = !fetch_fault & !redirect_valid & (occ_q + inflight_q - deq < 2).
  - On issue: inflight_d=1, inflight_pc_d=pc_q, pc_d=pc_q+4 (mod 2^32).
  - No issue: inflight_d=0 and pc_q holds. The ROM still reads, but the result is ignored.
- Capture: when inflight_q=1 and no redirect, push {inflight_pc_q, imem_instr} into the buffer at the next edge. Space is guaranteed by the issue rule; overflow is impossible and is an assertion.
- Latency:
  - A fetch issued at edge N appears on if_* after edge N+1.
  - The first if_valid comes 2 edges after rst_n is sampled high.
  - Steady-state throughput is 1 instr/cycle with id_ready held high.
- Stall (id_ready=0): the head holds stable. At most 2 entries are occupied plus 0 in flight, so no instruction is lost and none is fetched twice.
- Simultaneous push and pop with occ=1: the head advances to the pushed entry; occ stays 1.
- Redirect (redirect_valid=1) takes priority over everything:
  - Buffer is flushed (occ_d=0), inflight_d=0, pc_d=redirect_pc.
  - The target's ROM read happens at the following edge, so if_valid for the target rises 2 edges after the redirect edge.
  - Any deq in the redirect cycle is not counted in perf_fetched; decode squashes its own stage.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - Flush as above.
  - fetch_fault=1 and fault_pc=redirect_pc; both are sticky until reset.
  - No further issue; if_valid stays 0.
  - Later redirects are ignored.
- PC wrap: 32'hFFFF_FFFC+4 wraps to 0 with no flag. ROM address aliasing is outside this block.
- perf counters saturate at 32'hFFFF_FFFF.

Decomposition:
- riscv_pkg holds:
  - XLEN=32.
  - NOP_INSTR=32'h0000_0013.
  - RESET_PC default.
  - fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_buffer:
  - 2-entry FIFO of fetch_entry_t.
  - Ports: push, pop, flush, head, occupancy.
  - Synchronous active-low reset.
- fetch_unit keeps PC, inflight tracking, issue logic, fault and counters.

Test Plan:
- Reset release, ROM preloaded with word i = 32'h1000_0000+i, id_ready=1 -> if_valid rises 2 edges after release; if_pc = 0,4,8,... on consecutive cycles with matching instr; perf_fetched increments every cycle.
- Stall: id_ready=0 for 5 cycles at if_pc=0x10 -> if_pc/if_instr held at 0x10; after release the sequence is 0x10,0x14,0x18 with no gap, skip or duplicate; perf_stall=5.
- Redirect to 0x40 while 2 entries are buffered -> wrong-path entries are never presented; if_pc=0x40 appears 2 edges later, then 0x44.
- Redirect to 0x42 -> fetch_fault=1, fault_pc=0x42, if_valid stays 0 indefinitely; redirect to 0x80 afterwards is ignored; rst_n=0 clears the fault.
- rst_n=0 for one edge mid-stream with 2 buffered entries -> next cycle if_valid=0, occ=0, imem_addr=RESET_PC, counters=0.
- Random id_ready (50%) plus random aligned redirects, 10k cycles -> scoreboard: presented PCs follow the sequential/redirect model exactly; buffer-overflow assertion never fires.
